generic_bus_sram_responder: RTL

Responder (memory) end of `generic_bus_if`: accepts word read/write requests issued by the load/store unit or fetch path and answers them through the `busy` handshake after a parameterised number of wait states. It is the single-ported data-memory model used in core-level simulation and as the on-chip scratchpad in FPGA builds. It holds a byte-writable word array and inserts configurable latency.

---
 rtl/generic_bus_sram_responder_pkg.sv | 18 +
 rtl/generic_bus_sram_responder_if.sv | 21 ++
 rtl/generic_bus_sram_responder_sram_array.sv | 39 +++
 rtl/generic_bus_sram_responder.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/generic_bus_sram_responder_pkg.sv
// Shared types and constants for the generic bus SRAM responder.
// Imported by the responder top and its array.
package generic_bus_resp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } resp_state_t;

    localparam logic [31:0] BAD_ADDR_DATA = 32'hBAD1_BAD1;

    // Latency counter width; never narrower than one bit so LATENCY=0 builds.
    function automatic int cnt_width(input int latency);
        return (latency < 1) ? 1 : $clog2(latency + 1);
    endfunction

endpackage

// File: rtl/generic_bus_sram_responder_if.sv
// generic_bus_if: word request/response bus with a busy handshake.
// generic_bus is the responder side, cpu the initiator side.
interface generic_bus_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ren;
    logic        wen;
    logic        busy;
    logic [3:0]  byte_en;

    modport generic_bus (
        input  addr, wdata, ren, wen, byte_en,
        output rdata, busy
    );

    modport cpu (
        output addr, wdata, ren, wen, byte_en,
        input  rdata, busy
    );
endinterface

// File: rtl/generic_bus_sram_responder_sram_array.sv
// Single-port word array with per-byte write enables and registered read.
// Contents are not reset; a read during a write returns the old word.
module sram_array #(
    parameter int ADDR_BITS = 10
) (
    input  logic                 CLK,
    input  logic                 en,
    input  logic [3:0]           we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata
);
    logic [31:0] mem [1<<ADDR_BITS];
    logic [31:0] rdata_q;
    logic [31:0] rdata_d;

    // read register captures the addressed word on every access
    always_comb begin
        rdata_d = rdata_q;
        if (en) begin
            rdata_d = mem[addr];
        end
    end

    // byte-lane writes and read-register update
    always_ff @(posedge CLK) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/generic_bus_sram_responder.sv
// Memory end of generic_bus_if: byte-writable word SRAM answering
// requests through busy after LATENCY wait states.
module generic_bus_sram_responder
    import generic_bus_resp_pkg::*;
#(
    parameter int          ADDR_BITS = 10,
    parameter int          LATENCY   = 2,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                      CLK,
    input  logic                      nRST,
    generic_bus_if.generic_bus        bus_if
);
    localparam int            CW       = cnt_width(LATENCY);
    localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    // byte span of the array; ADDR_BITS is expected to stay below 30
    localparam logic [31:0]   SPAN     = 32'd4 << ADDR_BITS;

    resp_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [3:0]    be_q, be_d;
    logic          ren_q, ren_d;
    logic          wen_q, wen_d;
    logic          bad_q, bad_d;

    logic          req;
    logic [31:0]   cur_addr;
    logic [31:0]   cur_wdata;
    logic [31:0]   cur_off;
    logic [3:0]    cur_be;
    logic          cur_ren;
    logic          cur_wen;
    logic          cur_inr;
    logic          issue;
    logic [3:0]    sram_we;
    logic [31:0]   sram_rdata;
    logic [31:0]   done_rdata;

    assign req = bus_if.ren | bus_if.wen;

    // live bus fields while accepting, latched fields afterwards
    always_comb begin
        cur_addr  = addr_q;
        cur_wdata = wdata_q;
        cur_be    = be_q;
        cur_ren   = ren_q;
        cur_wen   = wen_q;
        if (state_q == IDLE) begin
            cur_addr  = bus_if.addr;
            cur_wdata = bus_if.wdata;
            cur_be    = bus_if.byte_en;
            cur_ren   = bus_if.ren;
            cur_wen   = bus_if.wen;
        end
        cur_off = cur_addr - BASE_ADDR;
        cur_inr = cur_off < SPAN;
    end

    // next-state, counter and request latch
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        ren_d   = ren_q;
        wen_d   = wen_q;
        bad_d   = bad_q;
        issue   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    addr_d  = bus_if.addr;
                    wdata_d = bus_if.wdata;
                    be_d    = bus_if.byte_en;
                    ren_d   = bus_if.ren;
                    wen_d   = bus_if.wen;
                    bad_d   = (bus_if.ren & bus_if.wen) | ~cur_inr;
                    cnt_d   = CNT_LOAD;
                    if (LATENCY == 0) begin
                        state_d = DONE;
                        issue   = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!req) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = DONE;
                        issue   = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // writes go only to in-range, write-only requests
    assign sram_we = (issue & cur_wen & ~cur_ren & cur_inr) ? cur_be : 4'h0;

    // response data is presented in DONE and held afterwards
    always_comb begin
        done_rdata = bad_q ? BAD_ADDR_DATA : sram_rdata;
        rdata_d    = (state_q == DONE) ? done_rdata : rdata_q;
    end

    // state and latch registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            bad_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            ren_q   <= ren_d;
            wen_q   <= wen_d;
            bad_q   <= bad_d;
            rdata_q <= rdata_d;
        end
    end

    sram_array #(
        .ADDR_BITS (ADDR_BITS)
    ) u_array (
        .CLK   (CLK),
        .en    (issue),
        .we    (sram_we),
        .addr  (cur_off[ADDR_BITS+1:2]),
        .wdata (cur_wdata),
        .rdata (sram_rdata)
    );

    assign bus_if.busy  = (state_q == WAIT) | ((state_q == IDLE) & req);
    assign bus_if.rdata = rdata_d;

endmodule
